load_store_unit: RTL

- Sits between the datapath and the data memory.
- Takes the ALU-computed address, store data, funct3 and a write strobe from the core. Turns them into word-aligned, byte-enabled requests over a valid/ready memory handshake.
- Returns sign- or zero-extended load data to the core.
- Stalls the core while an access is in flight, and flags misaligned or illegal accesses and memory timeouts instead of issuing them.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte-addressed accesses into word-aligned, byte-enabled
// memory requests over a valid/ready handshake and returns extended load data.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misaligned,
   output logic        timeout,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_misaligned;
   logic        r_timeout;

   logic        w_illegal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_load;

   function automatic logic f_illegal(input logic i_we, input logic [2:0] i_f3,
                                      input logic [1:0] i_off);
      logic l_bad_code;
      logic l_bad_align;
      if (i_we) l_bad_code = (i_f3 > 3'd2);
      else      l_bad_code = (i_f3 == 3'd3) || (i_f3 == 3'd6) || (i_f3 == 3'd7);
      case (i_f3[1:0])
         2'd1:    l_bad_align = i_off[0];
         2'd2:    l_bad_align = (i_off != 2'd0);
         default: l_bad_align = 1'b0;
      endcase
      return l_bad_code | l_bad_align;
   endfunction

   // Shift the addressed lane down to bit 0, then extend to the access width
   function automatic logic [31:0] f_extract(input logic [31:0] i_word, input logic [2:0] i_f3,
                                             input logic [1:0] i_off);
      logic [31:0] l_sh;
      l_sh = i_word >> {i_off, 3'b000};
      case (i_f3)
         3'd0:    return {{24{l_sh[7]}}, l_sh[7:0]};
         3'd4:    return {24'd0, l_sh[7:0]};
         3'd1:    return {{16{l_sh[15]}}, l_sh[15:0]};
         3'd5:    return {16'd0, l_sh[15:0]};
         default: return i_word;
      endcase
   endfunction

   assign w_illegal = f_illegal(req_we, req_funct3, req_addr[1:0]);
   assign w_load    = f_extract(mem_rdata, r_funct3, r_off);

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = 32'd0;
      if (req_we) begin
         case (req_funct3)
            3'd0: begin
               w_be    = 4'b0001 << req_addr[1:0];
               w_wdata = {4{req_wdata[7:0]}};
            end
            3'd1: begin
               w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = req_wdata;
            end
         endcase
      end
   end

   // Access attributes needed after accept; only meaningful while an access is in flight
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && req_valid) begin
         r_we     <= req_we;
         r_funct3 <= req_funct3;
         r_off    <= req_addr[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 8'd0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 32'd0;
         r_mem_be     <= 4'd0;
         r_mem_wdata  <= 32'd0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_misaligned <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         r_misaligned <= 1'b0;
         r_timeout    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_cnt <= 8'd0;
                  if (w_illegal) begin
                     r_state      <= S_ERR;
                     r_resp_valid <= 1'b1;
                     r_misaligned <= 1'b1;
                     r_resp_rdata <= 32'd0;
                  end else begin
                     r_state     <= S_ACCESS;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= req_we;
                     r_mem_addr  <= {req_addr[31:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                  end
               end
            end
            S_ACCESS: begin
               // A late answer in the last allowed cycle still wins over the timeout
               if (mem_ready) begin
                  r_state      <= S_DONE;
                  r_mem_req    <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= r_we ? 32'd0 : w_load;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_state      <= S_ERR;
                  r_mem_req    <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_timeout    <= 1'b1;
                  r_resp_rdata <= 32'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_resp_rdata <= 32'd0;
            end
         endcase
      end
   end

   assign stall      = (r_state == S_IDLE) ? req_valid : (r_state == S_ACCESS);
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign misaligned = r_misaligned;
   assign timeout    = r_timeout;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_be     = r_mem_be;
   assign mem_wdata  = r_mem_wdata;

endmodule
